// File: rtl/ftdi_cmd_sequencer.sv
// Command sequencer for the FT232H 245-fifo user side: parses 3-byte host commands,
// strobes register writes/reads and is the sole master of the TX byte stream.
module ftdi_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_tvalid,
    output logic       rx_tready,
    input  logic [7:0] rx_tdata,
    output logic       tx_tvalid,
    input  logic       tx_tready,
    output logic [7:0] tx_tdata,
    output logic       tx_tlast,
    input  logic       cap_tvalid,
    output logic       cap_tready,
    input  logic [7:0] cap_tdata,
    output logic       reg_wr,
    output logic       reg_rd,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_BURST = 8'h03;

    typedef enum logic [2:0] {
        GET0,
        GET1,
        GET2,
        EXEC,
        RD_WAIT,
        REPLY,
        BURST
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       op_q, op_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [15:0]      rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rx_accept;
    logic cap_xfer;

    assign rx_tready = (state_q == GET0) || (state_q == GET1) || (state_q == GET2);
    assign rx_accept = rx_tvalid && rx_tready;
    assign cap_xfer  = cap_tvalid && tx_tready;
    assign busy      = (state_q != GET0);
    assign reg_addr  = a_q;
    assign reg_wdata = b_q;

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        tx_data_d  = tx_data_q;
        rem_d      = rem_q;
        cnt_d      = '0;
        tx_tvalid  = 1'b0;
        tx_tdata   = tx_data_q;
        tx_tlast   = 1'b0;
        cap_tready = 1'b0;
        reg_wr     = 1'b0;
        reg_rd     = 1'b0;

        case (state_q)
            GET0: begin
                if (rx_accept) begin
                    op_d    = rx_tdata;
                    state_d = GET1;
                end
            end
            GET1, GET2: begin
                if (rx_accept) begin
                    if (state_q == GET1) begin
                        a_d     = rx_tdata;
                        state_d = GET2;
                    end else begin
                        b_d     = rx_tdata;
                        state_d = EXEC;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Host went quiet mid-command: drop the partial command.
                    state_d = GET0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                case (op_q)
                    OP_WRITE: begin
                        reg_wr  = 1'b1;
                        state_d = GET0;
                    end
                    OP_READ: begin
                        reg_rd  = 1'b1;
                        state_d = RD_WAIT;
                    end
                    OP_BURST: begin
                        if ({a_q, b_q} == 16'h0000) begin
                            state_d = GET0;
                        end else begin
                            rem_d   = {a_q, b_q};
                            state_d = BURST;
                        end
                    end
                    default: begin
                        tx_data_d = ERR_BYTE;
                        state_d   = REPLY;
                    end
                endcase
            end
            RD_WAIT: begin
                tx_data_d = reg_rdata;
                state_d   = REPLY;
            end
            REPLY: begin
                tx_tvalid = 1'b1;
                tx_tlast  = 1'b1;
                if (tx_tready) begin
                    state_d = GET0;
                end
            end
            BURST: begin
                tx_tvalid  = cap_tvalid;
                tx_tdata   = cap_tdata;
                tx_tlast   = (rem_q == 16'd1);
                cap_tready = tx_tready;
                if (cap_xfer) begin
                    if (rem_q == 16'd1) begin
                        rem_d   = '0;
                        state_d = GET0;
                    end else begin
                        rem_d = rem_q - 16'd1;
                    end
                end
            end
            default: begin
                state_d = GET0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= GET0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tx_data_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tx_data_q <= tx_data_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
